// File: rtl/arbitro_mem.sv
// Round-robin arbiter sharing one main-memory port between the PC translation unit (0)
// and the cache miss/write-back path (1). Define ARB_TIMEOUT_EN to abort unacknowledged transactions.
module arbitro_mem #(
  parameter int unsigned IND_W   = 16,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rdy0,
  input  logic [1:0]        op0,
  input  logic [IND_W-1:0]  ind0,
  input  logic [DATA_W-1:0] data0,
  input  logic              rdy1,
  input  logic [1:0]        op1,
  input  logic [IND_W-1:0]  ind1,
  input  logic [DATA_W-1:0] data1,
  output logic              ack0,
  output logic              ack1,
  output logic              esito,
  output logic [DATA_W-1:0] datain,
  output logic              rdyoutm,
  output logic [1:0]        opoutm,
  output logic [IND_W-1:0]  indoutm,
  output logic [DATA_W-1:0] dataoutm,
  input  logic              ackinm,
  input  logic              esitom,
  input  logic [DATA_W-1:0] datainm,
  output logic [1:0]        grant
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    REPLY = 2'b10
  } state_t;

  state_t state;
  logic   prio;
  logic   sel1;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] cnt;
`endif

  // Requester 1 wins when it is the only one asking, or on a tie when prio points to it.
  always_comb begin
    sel1 = 1'b0;
    sel1 = rdy1 && (!rdy0 || prio);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      prio     <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      esito    <= 1'b0;
      datain   <= '0;
      rdyoutm  <= 1'b0;
      opoutm   <= '0;
      indoutm  <= '0;
      dataoutm <= '0;
      grant    <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt      <= '0;
`endif
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (rdy0 || rdy1) begin
            opoutm   <= sel1 ? op1   : op0;
            indoutm  <= sel1 ? ind1  : ind0;
            dataoutm <= sel1 ? data1 : data0;
            grant    <= sel1 ? 2'b10 : 2'b01;
            rdyoutm  <= 1'b1;
            state    <= ISSUE;
`ifdef ARB_TIMEOUT_EN
            cnt      <= '0;
`endif
          end
        end
        ISSUE: begin
          if (ackinm) begin
            esito   <= esitom;
            datain  <= datainm;
            rdyoutm <= 1'b0;
            ack0    <= grant[0];
            ack1    <= grant[1];
            state   <= REPLY;
          end
`ifdef ARB_TIMEOUT_EN
          // Abort on the TIMEOUT-th silent cycle so rdyoutm stays high exactly TIMEOUT cycles.
          else if (cnt == TO_LAST) begin
            esito   <= 1'b1;
            datain  <= '0;
            rdyoutm <= 1'b0;
            ack0    <= grant[0];
            ack1    <= grant[1];
            state   <= REPLY;
          end else begin
            cnt <= cnt + 8'd1;
          end
`endif
        end
        REPLY: begin
          // Priority passes to the requester that was not just served.
          prio  <= grant[0];
          grant <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
